// File: rtl/axi_stream_if_m_connector_reg_if.sv
// rtl/axi_stream_if_m_connector_reg_if.sv - stream interface bundle with master/slave views
interface axi_stream_if;
  logic         valid;
  logic [511:0] data;
  logic [63:0]  keep;
  logic         last;
  logic [15:0]  user_size;
  logic [15:0]  user_src;
  logic [15:0]  user_dst;
  logic         ready;

  modport master (
    output valid, data, keep, last, user_size, user_src, user_dst,
    input  ready
  );

  modport slave (
    input  valid, data, keep, last, user_size, user_src, user_dst,
    output ready
  );
endinterface

// File: rtl/axi_stream_if_m_connector_reg.sv
// rtl/axi_stream_if_m_connector_reg.sv - interface array to flat stream vectors with per-lane skid buffer
module axi_stream_if_m_connector_reg #(
  parameter int COUNTS = 1,
  parameter int CNT_W  = 32
) (
  input  logic                      axis_aclk,
  input  logic                      axis_rst,
  axi_stream_if.slave               s_axis [COUNTS],
  output logic [COUNTS-1:0]         m_axis_tvalid,
  output logic [512*COUNTS-1:0]     m_axis_tdata,
  output logic [64*COUNTS-1:0]      m_axis_tkeep,
  output logic [COUNTS-1:0]         m_axis_tlast,
  output logic [16*COUNTS-1:0]      m_axis_tuser_size,
  output logic [16*COUNTS-1:0]      m_axis_tuser_src,
  output logic [16*COUNTS-1:0]      m_axis_tuser_dst,
  input  logic [COUNTS-1:0]         m_axis_tready,
  output logic [CNT_W*COUNTS-1:0]   pkt_count
);

  // Payload layout: {data, keep, last, user_size, user_src, user_dst}
  localparam int PW = 512 + 64 + 1 + 16 + 16 + 16;

  genvar g;
  generate
    for (g = 0; g < COUNTS; g++) begin : g_lane
      logic [PW-1:0]    w_in_pl;
      logic             w_ready;
      logic             w_tvalid;
      logic             w_in_hs;
      logic             w_out_hs;
      logic             w_main_free;
      logic [PW-1:0]    r_main_pl;
      logic [PW-1:0]    r_skid_pl;
      logic             r_out_valid;
      logic             r_skid_valid;
      logic [CNT_W-1:0] r_pkt_count;

      assign w_in_pl = {s_axis[g].data, s_axis[g].keep, s_axis[g].last,
                        s_axis[g].user_size, s_axis[g].user_src, s_axis[g].user_dst};

      // Ready depends only on the skid flag and reset, never on downstream ready.
      assign w_ready          = !r_skid_valid && !axis_rst;
      assign s_axis[g].ready  = w_ready;

      // Valid is forced low during reset so nothing leaves while buffers are being flushed.
      assign w_tvalid    = r_out_valid && !axis_rst;
      assign w_in_hs     = s_axis[g].valid && w_ready;
      assign w_out_hs    = w_tvalid && m_axis_tready[g];
      assign w_main_free = !r_out_valid || w_out_hs;

      // Payload registers carry no reset; contents are ignored while the matching valid is low.
      always_ff @(posedge axis_aclk) begin
        if (w_main_free) begin
          if (r_skid_valid) begin
            r_main_pl <= r_skid_pl;
          end else if (w_in_hs) begin
            r_main_pl <= w_in_pl;
          end
        end else if (w_in_hs) begin
          r_skid_pl <= w_in_pl;
        end
      end

      // Occupancy flags: refill main from skid first to keep beat order, else from input.
      always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
          r_out_valid  <= 1'b0;
          r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
          if (r_skid_valid) begin
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
          end else begin
            r_out_valid  <= w_in_hs;
          end
        end else if (w_in_hs) begin
          r_skid_valid <= 1'b1;
        end
      end

      // Packet counter advances on every accepted last beat and wraps silently.
      always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
          r_pkt_count <= '0;
        end else if (w_out_hs && r_main_pl[48]) begin
          r_pkt_count <= r_pkt_count + 1'b1;
        end
      end

      assign m_axis_tvalid[g]                = w_tvalid;
      assign m_axis_tdata[512*g +: 512]      = r_main_pl[624:113];
      assign m_axis_tkeep[64*g +: 64]        = r_main_pl[112:49];
      assign m_axis_tlast[g]                 = r_main_pl[48];
      assign m_axis_tuser_size[16*g +: 16]   = r_main_pl[47:32];
      assign m_axis_tuser_src[16*g +: 16]    = r_main_pl[31:16];
      assign m_axis_tuser_dst[16*g +: 16]    = r_main_pl[15:0];
      assign pkt_count[CNT_W*g +: CNT_W]     = r_pkt_count;
    end
  endgenerate

endmodule

// File: doc/axi_stream_if_m_connector_reg.md
Name: axi_stream_if_m_connector_reg

Overview:
Converts an array of axi_stream_if slave interfaces into flat, lane-concatenated AXI-stream master vectors, with one full-throughput register slice (skid buffer) per lane. It sits at the egress boundary of user-plugin logic that uses interfaces, feeding shell-side flat ports such as the box-to-QDMA or box-to-CMAC buses. Each lane also keeps a free-running packet counter.

Parameters:
COUNTS, 1, number of independent stream lanes (1..4).
CNT_W, 32, width of each per-lane packet counter.

Ports:
axis_aclk  input  1  single clock; all logic is on its rising edge.
axis_rst  input  1  synchronous, active-high reset.
s_axis  interface  axi_stream_if.slave[COUNTS]  input lanes; fields valid, data[512], keep[64], last, user_size[16], user_src[16], user_dst[16], ready.
m_axis_tvalid  output  COUNTS  per-lane valid.
m_axis_tdata  output  512*COUNTS  lane i at bits [512*i +: 512].
m_axis_tkeep  output  64*COUNTS  lane i at bits [64*i +: 64].
m_axis_tlast  output  COUNTS  per-lane last.
m_axis_tuser_size  output  16*COUNTS  lane i at bits [16*i +: 16].
m_axis_tuser_src  output  16*COUNTS  lane i at bits [16*i +: 16].
m_axis_tuser_dst  output  16*COUNTS  lane i at bits [16*i +: 16].
m_axis_tready  input  COUNTS  per-lane ready from the downstream sink.
pkt_count  output  CNT_W*COUNTS  lane i at bits [CNT_W*i +: CNT_W]; count of output packets.

Behaviour:
- Lanes are fully independent. No cross-lane ordering or coupling.
- Per-lane storage:
  - Main register: payload plus out_valid. Drives m_axis_*.
  - Skid register: payload plus skid_valid.
- Payload = data, keep, last, user_size, user_src, user_dst.
- Ready: s_axis[i].ready = !skid_valid && !axis_rst, driven from a register. There is no combinational path from m_axis_tready to s_axis.ready.
- Input handshake: s_axis[i].valid && s_axis[i].ready.
- Output handshake: m_axis_tvalid[i] && m_axis_tready[i].
- Next-state rules per cycle:
  - Main empty, or main accepted this cycle:
    - If skid_valid: move skid into main, clear skid_valid.
    - Else if input handshake: capture input into main, set out_valid.
    - Else: clear out_valid.
  - Main holding and not accepted, with an input handshake: capture input into skid, set skid_valid.
  - Main full, skid empty, output stalled, input arrives: input goes to skid and ready drops next cycle.
- Latency: exactly 1 cycle input to output when not stalled.
- Throughput: 1 beat per clock when m_axis_tready is held high.
- AXI rules:
  - Payload on m_axis_* is held stable while m_axis_tvalid=1 and m_axis_tready=0.
  - m_axis_tvalid never deasserts without a handshake.
- Beat ordering is preserved. No beat is dropped or duplicated, including when input and output handshakes happen in the same cycle with skid full.
- Packet counter: pkt_count lane i increments by 1 on each output handshake with m_axis_tlast=1. It wraps from 2^CNT_W-1 to 0 with no saturation or flag.
- Reset (synchronous, any cycle, including mid-packet):
  - Clears out_valid, skid_valid and pkt_count to 0.
  - m_axis_tvalid=0 and s_axis.ready=0 while axis_rst=1.
  - s_axis.ready=1 in the first cycle after axis_rst falls.
  - Buffered beats are discarded. Payload registers need no reset; their value is don't-care while valid=0.
- Upstream sources must not depend on ready before asserting valid. This block does not depend on valid to assert ready.

Test Plan:
- Pass-through: COUNTS=2, lane1 sends a 3-beat packet (data=beat index, keep=all ones on beats 0–1, 0x0000_0000_0000_00FF on the last beat, user_size=136, src=0x1, dst=0x2) with tready=1 -> output appears 1 cycle later, one beat per clock, fields bit-exact at [512+:512] etc.; lane0 tvalid stays 0; pkt_count lane1=1.
- Backpressure: stream 8 beats with tready toggling 1,0,0,1,… -> all 8 beats delivered in order, no duplicates; s_axis.ready low at most while skid is full; payload stable during every stall.
- Simultaneous events: skid full and tready rising in the same cycle as a new input beat -> exactly one beat accepted across the 2 cycles; order preserved (beat k, k+1, k+2 verified by data tag).
- Counter wrap: CNT_W=4, send 17 single-beat packets -> pkt_count goes 15 then 0, then 1.
- Reset mid-operation: assert axis_rst for 1 cycle with main and skid full on lane0 -> next cycle tvalid=0, pkt_count=0, ready=1; a following 1-beat packet emerges alone with no stale beat.
- Lane independence: COUNTS=4, random valid/tready per lane for 10k cycles -> per-lane scoreboard matches input beats, and pkt_count equals the number of tlast beats per lane.
